// File: rtl/sdram_port2_bridge.sv
// Client front end for the controller's 64-bit burst port: splits commands into
// legal port2 requests and buffers returned read words in a credit-managed FIFO.
module sdram_port2_bridge #(
  parameter int DEPTH     = 16,
  parameter int BURST_MAX = 8
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [23:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [63:0] wr_data,
  input  logic [7:0]  wr_be,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [63:0] rd_data,
  output logic        rd_last,
  output logic        idle,
  output logic        port2_req,
  input  logic        port2_busy,
  output logic        port2_we,
  output logic [7:0]  port2_burstcnt,
  output logic [23:0] port2_a,
  output logic [7:0]  port2_ds,
  output logic [63:0] port2_d,
  input  logic [63:0] port2_q,
  input  logic        port2_ack
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_DATA, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_RD_DRAIN
  } state_t;

  state_t        r_state, w_state_next;
  logic          r_we, w_we_next;
  logic [23:0]   r_addr, w_addr_next;
  logic [7:0]    r_remaining, w_remaining_next;
  logic          r_req, w_req_next;
  logic          r_p2_we, w_p2_we_next;
  logic [7:0]    r_p2_burstcnt, w_p2_burstcnt_next;
  logic [23:0]   r_p2_a, w_p2_a_next;
  logic [7:0]    r_p2_ds, w_p2_ds_next;
  logic [63:0]   r_p2_d, w_p2_d_next;
  logic [CW-1:0] r_outstanding, w_outstanding_next;
  logic [CW-1:0] r_count, w_count_next;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [64:0]   r_mem [DEPTH];

  logic [7:0]    w_chunk;
  logic [15:0]   w_credit;
  logic          w_issue;
  logic          w_ack_ok;
  logic          w_push;
  logic          w_pop;
  logic          w_last_tag;
  logic          w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = ^cmd_addr[2:0];

  assign w_chunk  = (r_remaining > 8'(BURST_MAX)) ? 8'(BURST_MAX) : r_remaining;
  // Room not yet promised to in-flight words; an ack can therefore never hit a full FIFO.
  assign w_credit = 16'(DEPTH) - 16'(r_count) - 16'(r_outstanding);

  always_comb begin
    w_state_next       = r_state;
    w_we_next          = r_we;
    w_addr_next        = r_addr;
    w_remaining_next   = r_remaining;
    w_req_next         = 1'b0;
    w_p2_we_next       = r_p2_we;
    w_p2_burstcnt_next = r_p2_burstcnt;
    w_p2_a_next        = r_p2_a;
    w_p2_ds_next       = r_p2_ds;
    w_p2_d_next        = r_p2_d;
    w_issue            = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_we_next        = cmd_we;
          w_addr_next      = {cmd_addr[23:3], 3'b000};
          w_remaining_next = cmd_len;
          if (cmd_len != 8'd0) w_state_next = cmd_we ? S_WR_DATA : S_RD_REQ;
        end
      end
      S_WR_DATA: begin
        if (wr_valid) begin
          w_p2_d_next  = wr_data;
          w_p2_ds_next = wr_be;
          w_state_next = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (!port2_busy && !r_req) begin
          w_req_next         = 1'b1;
          w_p2_we_next       = 1'b1;
          w_p2_burstcnt_next = 8'd1;
          w_p2_a_next        = r_addr;
          w_state_next       = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        // The req cycle itself is skipped: busy only rises after the controller sees req.
        if (!r_req && !port2_busy) begin
          w_addr_next      = r_addr + 24'd8;
          w_remaining_next = r_remaining - 8'd1;
          w_state_next     = (r_remaining == 8'd1) ? S_IDLE : S_WR_DATA;
        end
      end
      S_RD_REQ: begin
        if (!port2_busy && !r_req && (w_credit >= {8'd0, w_chunk})) begin
          w_issue            = 1'b1;
          w_req_next         = 1'b1;
          w_p2_we_next       = 1'b0;
          w_p2_burstcnt_next = w_chunk;
          w_p2_a_next        = r_addr;
          w_p2_ds_next       = 8'hFF;
          w_addr_next        = r_addr + {13'd0, w_chunk, 3'b000};
          w_remaining_next   = r_remaining - w_chunk;
          w_state_next       = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (!r_req && !port2_busy)
          w_state_next = (r_remaining != 8'd0) ? S_RD_REQ : S_RD_DRAIN;
      end
      S_RD_DRAIN: begin
        if (r_outstanding == '0) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Acks with nothing outstanding are protocol errors and are dropped.
  assign w_ack_ok   = port2_ack && (r_outstanding != '0);
  assign w_push     = w_ack_ok && (r_count != CW'(DEPTH));
  assign w_pop      = rd_ready && (r_count != '0);
  assign w_last_tag = (r_outstanding == CW'(1)) && (r_remaining == 8'd0);

  always_comb begin
    w_outstanding_next = r_outstanding
                       + (w_issue  ? CW'(w_chunk) : '0)
                       - (w_ack_ok ? CW'(1)       : '0);
    w_count_next       = r_count
                       + (w_push ? CW'(1) : '0)
                       - (w_pop  ? CW'(1) : '0);
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_state       <= S_IDLE;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_req         <= 1'b0;
      r_p2_we       <= 1'b0;
      r_p2_burstcnt <= '0;
      r_p2_a        <= '0;
      r_p2_ds       <= '0;
      r_p2_d        <= '0;
      r_outstanding <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_state       <= w_state_next;
      r_we          <= w_we_next;
      r_addr        <= w_addr_next;
      r_remaining   <= w_remaining_next;
      r_req         <= w_req_next;
      r_p2_we       <= w_p2_we_next;
      r_p2_burstcnt <= w_p2_burstcnt_next;
      r_p2_a        <= w_p2_a_next;
      r_p2_ds       <= w_p2_ds_next;
      r_p2_d        <= w_p2_d_next;
      r_outstanding <= w_outstanding_next;
      r_count       <= w_count_next;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {w_last_tag, port2_q};
  end

  assign cmd_ready      = (r_state == S_IDLE);
  assign wr_ready       = (r_state == S_WR_DATA);
  assign rd_valid       = (r_count != '0);
  assign rd_data        = r_mem[r_rptr][63:0];
  assign rd_last        = rd_valid && r_mem[r_rptr][64];
  assign idle           = (r_state == S_IDLE) && (r_count == '0);
  assign port2_req      = r_req;
  assign port2_we       = r_p2_we;
  assign port2_burstcnt = r_p2_burstcnt;
  assign port2_a        = r_p2_a;
  assign port2_ds       = r_p2_ds;
  assign port2_d        = r_p2_d;

endmodule

// File: tb/tb_sdram_port2_bridge.sv
// Bench for sdram_port2_bridge: controller and consumer models, table vectors,
// randomized commands against a queue-based reference, and hand-built corner cases.
module tb_sdram_port2_bridge;

  localparam int DEPTH     = 16;
  localparam int BURST_MAX = 8;

  logic        clk = 1'b0;
  logic        init_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [23:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic        rd_valid, rd_ready, rd_last, idle;
  logic [63:0] rd_data;
  logic        port2_req, port2_busy, port2_we, port2_ack;
  logic [7:0]  port2_burstcnt, port2_ds;
  logic [23:0] port2_a;
  logic [63:0] port2_d, port2_q;

  always #5 clk = ~clk;

  sdram_port2_bridge #(.DEPTH(DEPTH), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .init_n(init_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .idle(idle),
    .port2_req(port2_req), .port2_busy(port2_busy), .port2_we(port2_we),
    .port2_burstcnt(port2_burstcnt), .port2_a(port2_a), .port2_ds(port2_ds),
    .port2_d(port2_d), .port2_q(port2_q), .port2_ack(port2_ack)
  );

  typedef struct packed {
    logic        we;
    logic [7:0]  cnt;
    logic [23:0] a;
    logic [7:0]  ds;
    logic [63:0] d;
  } req_t;

  typedef struct {
    logic        we;
    logic [23:0] addr;
    int          len;
    int          mode;
    int          exp_nreq;
    logic [7:0]  exp_last_cnt;
    logic [23:0] exp_last_a;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  req_t        req_log[$];
  req_t        exp_req[$];
  logic [64:0] got_q[$];
  logic [64:0] exp_words[$];
  logic [63:0] pending[$];
  logic [63:0] wd [256];
  logic [7:0]  wb [256];
  int          ack_budget = -1;
  int          ack_rate = 100;
  int          cons_mode = 0;
  int          busy_cnt = 0;
  logic        prev_req = 1'b0;
  time         last_ack_time = 0;
  time         last_pop_time = 0;
  vec_t        vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_req(input string name, input req_t act, input req_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual we=%0d cnt=%0d a=%06h ds=%02h d=%016h required we=%0d cnt=%0d a=%06h ds=%02h d=%016h",
               name, act.we, act.cnt, act.a, act.ds, act.d, exp.we, exp.cnt, exp.a, exp.ds, exp.d);
    end
  endtask

  function automatic logic [63:0] data_of(input logic [23:0] a);
    return {8'h5A, a, 8'hC3, ~a};
  endfunction

  function automatic req_t mk_req(input logic we, input logic [7:0] cnt, input logic [23:0] a,
                                  input logic [7:0] ds, input logic [63:0] d);
    req_t r;
    r.we = we; r.cnt = cnt; r.a = a; r.ds = ds; r.d = d;
    return r;
  endfunction

  // Controller model: busy for a few cycles after each req, read words returned in order.
  initial begin
    port2_busy = 1'b0;
    port2_ack  = 1'b0;
    port2_q    = '0;
    forever begin
      @(negedge clk);
      port2_ack = 1'b0;
      if (busy_cnt > 0) busy_cnt--;
      if (port2_req) begin
        chk("req_while_busy", 64'(port2_busy), 64'd0);
        chk("req_back_to_back", 64'(prev_req), 64'd0);
        req_log.push_back(mk_req(port2_we, port2_burstcnt, port2_a, port2_ds,
                                 port2_we ? port2_d : 64'd0));
        if (!port2_we)
          for (int i = 0; i < int'(port2_burstcnt); i++)
            pending.push_back(data_of(port2_a + 24'(8 * i)));
        busy_cnt = $urandom_range(1, 4);
      end
      prev_req   = port2_req;
      port2_busy = (busy_cnt > 0);
      if (pending.size() > 0 && ack_budget != 0 && $urandom_range(0, 99) < ack_rate) begin
        port2_ack = 1'b1;
        port2_q   = pending.pop_front();
        if (ack_budget > 0) ack_budget--;
        last_ack_time = $time;
      end
    end
  end

  // Consumer: 0 stalled, 1 random, 2 always ready, 3 pop a single word then stall.
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (cons_mode)
        1: rd_ready = ($urandom_range(0, 2) != 0);
        2: rd_ready = 1'b1;
        3: begin
          rd_ready = rd_valid;
          if (rd_valid) cons_mode = 0;
        end
        default: rd_ready = 1'b0;
      endcase
      if (rd_ready && rd_valid && init_n) begin
        got_q.push_back({rd_last, rd_data});
        last_pop_time = $time;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic add_read_words(input logic [23:0] addr, input int len);
    logic [23:0] base;
    base = {addr[23:3], 3'b000};
    for (int i = 0; i < len; i++)
      exp_words.push_back({(i == len - 1), data_of(base + 24'(8 * i))});
  endtask

  task automatic model(input logic we, input logic [23:0] addr, input int len);
    logic [23:0] a;
    int rem, c;
    a = {addr[23:3], 3'b000};
    rem = len;
    exp_req.delete();
    exp_words.delete();
    if (we) begin
      for (int i = 0; i < len; i++)
        exp_req.push_back(mk_req(1'b1, 8'd1, a + 24'(8 * i), wb[i], wd[i]));
    end else begin
      while (rem > 0) begin
        c = (rem < BURST_MAX) ? rem : BURST_MAX;
        exp_req.push_back(mk_req(1'b0, 8'(c), a, 8'hFF, 64'd0));
        a = a + 24'(8 * c);
        rem = rem - c;
      end
      add_read_words(addr, len);
    end
  endtask

  task automatic send_cmd(input logic we, input logic [23:0] addr, input int len);
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_len   = 8'(len);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = 24'($urandom);
    cmd_len   = 8'($urandom);
  endtask

  task automatic feed_writes(input int len);
    int i, t;
    i = 0;
    t = 0;
    while (i < len && t < 4000) begin
      @(negedge clk);
      t++;
      if ($urandom_range(0, 3) == 0) begin
        wr_valid = 1'b0;
      end else begin
        wr_valid = 1'b1;
        wr_data  = wd[i];
        wr_be    = wb[i];
        if (wr_ready) i++;
      end
    end
    chk("wr_words_taken", 64'(i), 64'(len));
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int need);
    int t;
    t = 0;
    while (!(idle && req_log.size() >= exp_req.size() && got_q.size() >= need) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("done_idle", 64'(idle), 64'd1);
  endtask

  task automatic compare_all(input string tag);
    int n;
    chk($sformatf("%s_nreq", tag), 64'(req_log.size()), 64'(exp_req.size()));
    n = (req_log.size() < exp_req.size()) ? req_log.size() : exp_req.size();
    for (int i = 0; i < n; i++)
      chk_req($sformatf("%s_req%0d", tag, i), req_log[i], exp_req[i]);
    chk($sformatf("%s_nwords", tag), 64'(got_q.size()), 64'(exp_words.size()));
    n = (got_q.size() < exp_words.size()) ? got_q.size() : exp_words.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_word%0d_data", tag, i), got_q[i][63:0], exp_words[i][63:0]);
      chk($sformatf("%s_word%0d_last", tag, i), 64'(got_q[i][64]), 64'(exp_words[i][64]));
    end
  endtask

  task automatic run_cmd(input string tag, input logic we, input logic [23:0] addr,
                         input int len, input int mode);
    for (int i = 0; i < len; i++) begin
      wd[i] = {$urandom, $urandom};
      wb[i] = 8'($urandom);
    end
    model(we, addr, len);
    req_log.delete();
    got_q.delete();
    cons_mode = mode;
    send_cmd(we, addr, len);
    if (we && len > 0) feed_writes(len);
    wait_done(we ? 0 : len);
    compare_all(tag);
    $display("%s we=%0d addr=%06h len=%0d reqs=%0d words=%0d", tag, we, addr, len,
             req_log.size(), got_q.size());
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_wr_ready"}, 64'(wr_ready), 64'd0);
    chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    chk({tag, "_rd_last"}, 64'(rd_last), 64'd0);
    chk({tag, "_idle"}, 64'(idle), 64'd1);
    chk({tag, "_req"}, 64'(port2_req), 64'd0);
    chk({tag, "_we"}, 64'(port2_we), 64'd0);
    chk({tag, "_burstcnt"}, 64'(port2_burstcnt), 64'd0);
    chk({tag, "_a"}, 64'(port2_a), 64'd0);
    chk({tag, "_ds"}, 64'(port2_ds), 64'd0);
    chk({tag, "_d"}, port2_d, 64'd0);
  endtask

  initial begin
    logic seen_valid;
    int t;
    init_n    = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid  = 1'b0; wr_data = '0; wr_be = '0;

    vecs[0] = '{1'b1, 24'h000103,   3, 2,  3, 8'd1, 24'h000110};
    vecs[1] = '{1'b0, 24'h000000,  20, 2,  3, 8'd4, 24'h000080};
    vecs[2] = '{1'b0, 24'h000000,   0, 2,  0, 8'd0, 24'h000000};
    vecs[3] = '{1'b1, 24'h000055,   0, 2,  0, 8'd0, 24'h000000};
    vecs[4] = '{1'b1, 24'hFFFFF8,   2, 2,  2, 8'd1, 24'h000000};
    vecs[5] = '{1'b0, 24'hFFFFF0,   9, 2,  2, 8'd1, 24'h000030};
    vecs[6] = '{1'b0, 24'h00123F,   8, 1,  1, 8'd8, 24'h001238};
    vecs[7] = '{1'b0, 24'h000008,   1, 2,  1, 8'd1, 24'h000008};
    vecs[8] = '{1'b1, 24'h000040,   1, 2,  1, 8'd1, 24'h000040};
    vecs[9] = '{1'b0, 24'h000100, 255, 1, 32, 8'd7, 24'h0008C0};

    #23;
    chk_reset_outputs("rst");
    @(negedge clk);
    init_n = 1'b1;
    wait_cycles(2);

    for (int v = 0; v < 10; v++) begin
      run_cmd($sformatf("tbl%0d", v), vecs[v].we, vecs[v].addr, vecs[v].len, vecs[v].mode);
      chk($sformatf("tbl%0d_nreq_const", v), 64'(req_log.size()), 64'(vecs[v].exp_nreq));
      if (vecs[v].exp_nreq > 0 && req_log.size() > 0) begin
        chk($sformatf("tbl%0d_last_cnt", v), 64'(req_log[req_log.size() - 1].cnt),
            64'(vecs[v].exp_last_cnt));
        chk($sformatf("tbl%0d_last_a", v), 64'(req_log[req_log.size() - 1].a),
            64'(vecs[v].exp_last_a));
      end
      if (vecs[v].len == 0) chk($sformatf("tbl%0d_cmd_ready", v), 64'(cmd_ready), 64'd1);
    end

    // Stalled consumer: two bursts fill the FIFO, then a one-word read waits for credit.
    req_log.delete(); got_q.delete(); exp_words.delete();
    cons_mode = 0; ack_rate = 100; ack_budget = -1;
    send_cmd(1'b0, 24'h000200, 16);
    wait_cycles(60);
    chk("credit_nreq_two", 64'(req_log.size()), 64'd2);
    chk("credit_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("credit_idle_busy_fifo", 64'(idle), 64'd0);
    send_cmd(1'b0, 24'h000300, 1);
    wait_cycles(30);
    chk("credit_no_req", 64'(req_log.size()), 64'd2);
    cons_mode = 3;
    t = 0;
    while (req_log.size() < 3 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("credit_req_after_pop", 64'(req_log.size()), 64'd3);
    if (req_log.size() >= 3)
      chk_req("credit_req3", req_log[2], mk_req(1'b0, 8'd1, 24'h000300, 8'hFF, 64'd0));
    cons_mode = 2;
    exp_req.delete();
    add_read_words(24'h000200, 16);
    add_read_words(24'h000300, 1);
    wait_done(17);
    exp_req = req_log;
    compare_all("credit");
    $display("credit seq reqs=%0d words=%0d", req_log.size(), got_q.size());

    // Ack and pop land in the same cycle with the FIFO one short of full.
    req_log.delete(); got_q.delete(); exp_words.delete();
    cons_mode = 0; ack_budget = 15;
    send_cmd(1'b0, 24'h000400, 16);
    wait_cycles(60);
    chk("simul_nreq", 64'(req_log.size()), 64'd2);
    chk("simul_draining", 64'(cmd_ready), 64'd0);
    chk("simul_no_pops", 64'(got_q.size()), 64'd0);
    @(posedge clk);
    ack_budget = 1;
    cons_mode  = 3;
    @(posedge clk);
    #1;
    chk("simul_same_cycle", 64'(last_ack_time), 64'(last_pop_time));
    chk("simul_one_popped", 64'(got_q.size()), 64'd1);
    chk("simul_head_valid", 64'(rd_valid), 64'd1);
    ack_budget = -1;
    cons_mode  = 2;
    exp_req.delete();
    add_read_words(24'h000400, 16);
    wait_done(16);
    exp_req = req_log;
    compare_all("simul");
    $display("simul seq reqs=%0d words=%0d", req_log.size(), got_q.size());

    for (int n = 0; n < 30; n++) begin
      ack_rate = $urandom_range(25, 100);
      run_cmd($sformatf("rnd%0d", n), 1'($urandom), 24'($urandom),
              ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40), $urandom_range(1, 2));
    end
    ack_rate = 100;

    // Reset with five read words still outstanding; the late acks must be dropped.
    req_log.delete(); got_q.delete();
    cons_mode = 0; ack_budget = 3;
    send_cmd(1'b0, 24'h000800, 8);
    wait_cycles(20);
    chk("rst_mid_nreq", 64'(req_log.size()), 64'd1);
    chk("rst_mid_fifo_has_data", 64'(rd_valid), 64'd1);
    #2;
    init_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    wait_cycles(2);
    init_n = 1'b1;
    ack_budget = -1;
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_valid) seen_valid = 1'b1;
    end
    chk("rst_stray_rd_valid", 64'(seen_valid), 64'd0);
    chk("rst_stray_nreq", 64'(req_log.size()), 64'd1);
    chk("rst_stray_idle", 64'(idle), 64'd1);
    $display("reset seq stray_acks_left=%0d rd_valid_seen=%0d", pending.size(), seen_valid);
    pending.delete();

    run_cmd("recover", 1'b0, 24'h000900, 4, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
